// File: rtl/simple_bus_xbar.sv
// simple_bus_xbar: single-cycle req/gnt/rvalid interconnect from NrHosts masters to NrDevices
// memory-mapped slaves.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   host_req_i / host_gnt_o      per-host request and same-cycle grant
//   host_addr_i, host_we_i,
//   host_be_i, host_wdata_i      per-host request payload
//   host_rvalid_o, host_rdata_o,
//   host_err_o                   per-host response, one cycle after the grant
//   device_req_o, device_addr_o,
//   device_we_o, device_be_o,
//   device_wdata_o               per-device forwarded request
//   device_rvalid_i,
//   device_rdata_i, device_err_i per-device response
//   cfg_device_addr_base/mask    per-device address decode table
//
// Arbitration is fixed priority (lowest host index wins); decode picks the lowest matching device.
//
// Optional feature, macro BUS_DECODE_ERR_EN: unmapped requests are granted and answered next
// cycle with err=1. Without it, unmapped requests are never granted and the host stalls.

module simple_bus_xbar #(
  parameter int unsigned NrDevices    = 1,
  parameter int unsigned NrHosts      = 1,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddressWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    host_req_i           [NrHosts],
  output logic                    host_gnt_o           [NrHosts],
  input  logic [AddressWidth-1:0] host_addr_i          [NrHosts],
  input  logic                    host_we_i            [NrHosts],
  input  logic [DataWidth/8-1:0]  host_be_i            [NrHosts],
  input  logic [DataWidth-1:0]    host_wdata_i         [NrHosts],
  output logic                    host_rvalid_o        [NrHosts],
  output logic [DataWidth-1:0]    host_rdata_o         [NrHosts],
  output logic                    host_err_o           [NrHosts],

  output logic                    device_req_o         [NrDevices],
  output logic [AddressWidth-1:0] device_addr_o        [NrDevices],
  output logic                    device_we_o          [NrDevices],
  output logic [DataWidth/8-1:0]  device_be_o          [NrDevices],
  output logic [DataWidth-1:0]    device_wdata_o       [NrDevices],
  input  logic                    device_rvalid_i      [NrDevices],
  input  logic [DataWidth-1:0]    device_rdata_i       [NrDevices],
  input  logic                    device_err_i         [NrDevices],

  input  logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices]
);

  localparam int unsigned HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
  localparam int unsigned BeWidth  = DataWidth / 8;

  // Arbitration: walk downwards so the lowest requesting index is the last one written.
  logic                    sel_valid;
  logic [HostIdxW-1:0]     sel_host;
  logic [AddressWidth-1:0] sel_addr;
  logic                    sel_we;
  logic [BeWidth-1:0]      sel_be;
  logic [DataWidth-1:0]    sel_wdata;

  always_comb begin
    sel_valid = 1'b0;
    sel_host  = '0;
    sel_addr  = host_addr_i[0];
    sel_we    = host_we_i[0];
    sel_be    = host_be_i[0];
    sel_wdata = host_wdata_i[0];
    for (int h = int'(NrHosts) - 1; h >= 0; h--) begin
      if (host_req_i[h]) begin
        sel_valid = 1'b1;
        sel_host  = HostIdxW'(h);
        sel_addr  = host_addr_i[h];
        sel_we    = host_we_i[h];
        sel_be    = host_be_i[h];
        sel_wdata = host_wdata_i[h];
      end
    end
  end

  // Address decode, lowest matching device wins.
  logic               dev_match;
  logic [DevIdxW-1:0] dev_sel;

  always_comb begin
    dev_match = 1'b0;
    dev_sel   = '0;
    for (int d = int'(NrDevices) - 1; d >= 0; d--) begin
      if ((sel_addr & cfg_device_addr_mask[d]) ==
          (cfg_device_addr_base[d] & cfg_device_addr_mask[d])) begin
        dev_match = 1'b1;
        dev_sel   = DevIdxW'(d);
      end
    end
  end

  logic grant;

`ifdef BUS_DECODE_ERR_EN
  assign grant = sel_valid & ~rst_i;
`else
  assign grant = sel_valid & dev_match & ~rst_i;
`endif

  always_comb begin
    for (int h = 0; h < int'(NrHosts); h++) begin
      host_gnt_o[h] = grant && (sel_host == HostIdxW'(h));
    end
    // Unselected devices see the winner's payload; only req qualifies it.
    for (int d = 0; d < int'(NrDevices); d++) begin
      device_req_o[d]   = grant && dev_match && (dev_sel == DevIdxW'(d));
      device_addr_o[d]  = sel_addr;
      device_we_o[d]    = sel_we;
      device_be_o[d]    = sel_be;
      device_wdata_o[d] = sel_wdata;
    end
  end

  // Response tracking for the one-cycle pipeline.
  logic                valid_q;
  logic [HostIdxW-1:0] host_q;
  logic [DevIdxW-1:0]  dev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      host_q  <= '0;
      dev_q   <= '0;
    end else begin
      valid_q <= grant;
      if (grant) begin
        host_q <= sel_host;
        dev_q  <= dev_sel;
      end
    end
  end

`ifdef BUS_DECODE_ERR_EN
  logic dec_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dec_err_q <= 1'b0;
    end else begin
      dec_err_q <= grant & ~dev_match;
    end
  end
`endif

  // Response mux from the registered device index.
  logic                 rsp_rvalid;
  logic [DataWidth-1:0] rsp_rdata;
  logic                 rsp_err;

  always_comb begin
    rsp_rvalid = 1'b0;
    rsp_rdata  = '0;
    rsp_err    = 1'b0;
    for (int d = 0; d < int'(NrDevices); d++) begin
      if (dev_q == DevIdxW'(d)) begin
        rsp_rvalid = device_rvalid_i[d];
        rsp_rdata  = device_rdata_i[d];
        rsp_err    = device_err_i[d];
      end
    end
`ifdef BUS_DECODE_ERR_EN
    if (dec_err_q) begin
      rsp_rvalid = 1'b1;
      rsp_rdata  = '0;
      rsp_err    = 1'b1;
    end
`endif
  end

  // Responses are suppressed while reset is held so a late device answer cannot leak through.
  always_comb begin
    for (int h = 0; h < int'(NrHosts); h++) begin
      if (!rst_i && valid_q && (host_q == HostIdxW'(h))) begin
        host_rvalid_o[h] = rsp_rvalid;
        host_rdata_o[h]  = rsp_rdata;
        host_err_o[h]    = rsp_err;
      end else begin
        host_rvalid_o[h] = 1'b0;
        host_rdata_o[h]  = '0;
        host_err_o[h]    = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_simple_bus_xbar.sv
module tb_simple_bus_xbar;

  localparam int NH = 2;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        host_req    [NH];
  logic        host_gnt_o  [NH];
  logic [31:0] host_addr   [NH];
  logic        host_we     [NH];
  logic [3:0]  host_be     [NH];
  logic [31:0] host_wdata  [NH];
  logic        host_rvalid_o [NH];
  logic [31:0] host_rdata_o  [NH];
  logic        host_err_o    [NH];

  logic        device_req_o   [ND];
  logic [31:0] device_addr_o  [ND];
  logic        device_we_o    [ND];
  logic [3:0]  device_be_o    [ND];
  logic [31:0] device_wdata_o [ND];
  logic        device_rvalid_i [ND];
  logic [31:0] device_rdata_i  [ND];
  logic        device_err_i    [ND];
  logic [31:0] cfg_base [ND];
  logic [31:0] cfg_mask [ND];

  simple_bus_xbar #(
    .NrDevices   (ND),
    .NrHosts     (NH),
    .DataWidth   (32),
    .AddressWidth(32)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .host_req_i          (host_req),
    .host_gnt_o          (host_gnt_o),
    .host_addr_i         (host_addr),
    .host_we_i           (host_we),
    .host_be_i           (host_be),
    .host_wdata_i        (host_wdata),
    .host_rvalid_o       (host_rvalid_o),
    .host_rdata_o        (host_rdata_o),
    .host_err_o          (host_err_o),
    .device_req_o        (device_req_o),
    .device_addr_o       (device_addr_o),
    .device_we_o         (device_we_o),
    .device_be_o         (device_be_o),
    .device_wdata_o      (device_wdata_o),
    .device_rvalid_i     (device_rvalid_i),
    .device_rdata_i      (device_rdata_i),
    .device_err_i        (device_err_i),
    .cfg_device_addr_base(cfg_base),
    .cfg_device_addr_mask(cfg_mask)
  );

  // Device model: answers every request exactly one cycle later.
  logic [31:0] dev_data [ND];
  logic        dev_err  [ND];
  logic        force_rvalid;
  logic        dev_rvalid_q [ND];
  logic [31:0] dev_rdata_q  [ND];
  logic        dev_err_q    [ND];

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      dev_rvalid_q[d] <= device_req_o[d];
      dev_rdata_q[d]  <= dev_data[d];
      dev_err_q[d]    <= device_req_o[d] & dev_err[d];
    end
  end

  always_comb begin
    for (int d = 0; d < ND; d++) begin
      device_rvalid_i[d] = dev_rvalid_q[d] | force_rvalid;
      device_rdata_i[d]  = dev_rdata_q[d];
      device_err_i[d]    = dev_err_q[d];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          host;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t exp_q[$];

  // Scoreboard monitor: compares every host response port once per cycle.
  always @(posedge clk) begin
    exp_t e;
    logic        xv;
    logic        xe;
    logic [31:0] xd;
    #4;
    if (rst) begin
      for (int h = 0; h < NH; h++) begin
        checks++;
        if (host_rvalid_o[h] !== 1'b0 || host_err_o[h] !== 1'b0) begin
          errors++;
          $display("FAIL rsp_in_reset host%0d: got rvalid=%b err=%b, expected 0 0", h,
                   host_rvalid_o[h], host_err_o[h]);
        end
      end
      exp_q.delete();
    end else begin
      e.host = -1; e.rdata = '0; e.err = 1'b0; e.due = 0;
      if (exp_q.size() != 0 && exp_q[0].due == cyc) e = exp_q.pop_front();
      for (int h = 0; h < NH; h++) begin
        xv = (h == e.host);
        xe = xv ? e.err : 1'b0;
        xd = xv ? e.rdata : 32'h0;
        checks++;
        if (host_rvalid_o[h] !== xv || host_err_o[h] !== xe || host_rdata_o[h] !== xd) begin
          errors++;
          $display("FAIL rsp host%0d cyc%0d: got rvalid=%b err=%b rdata=%h, expected %b %b %h",
                   h, cyc, host_rvalid_o[h], host_err_o[h], host_rdata_o[h], xv, xe, xd);
        end
      end
    end
  end

  function automatic logic [2:0] dreq_vec();
    return {device_req_o[2], device_req_o[1], device_req_o[0]};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      for (int h = 0; h < NH; h++) host_req[h] = 1'b0;
    end
  endtask

  task automatic drive(input int h, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wdata);
    host_req[h] = 1'b1; host_addr[h] = addr; host_we[h] = we;
    host_be[h] = be; host_wdata[h] = wdata;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 32'h100080, 1'b0, 4'hF, 32'h0);
    repeat (3) begin
      @(posedge clk); #3;
      checks++;
      if (host_gnt_o[0] !== 1'b0 || dreq_vec() !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold: got gnt0=%b dreq=%b, expected 0 000", host_gnt_o[0], dreq_vec());
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    host_req[0] = 1'b0;
    #2;
    checks++;
    if (host_rvalid_o[0] !== 1'b0 || host_err_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_cycle: got rvalid=%b err=%b, expected 0 0",
               host_rvalid_o[0], host_err_o[0]);
    end
    idle(1);
  endtask

  task automatic test_read();
    @(posedge clk); #1;
    drive(0, 32'h100080, 1'b0, 4'hF, 32'h0);
    #2;
    checks++;
    if (host_gnt_o[0] !== 1'b1 || host_gnt_o[1] !== 1'b0 || dreq_vec() !== 3'b001) begin
      errors++;
      $display("FAIL read_req: got gnt=%b%b dreq=%b, expected 01 001", host_gnt_o[1],
               host_gnt_o[0], dreq_vec());
    end
    checks++;
    if (device_addr_o[0] !== 32'h100080 || device_we_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL read_addr: got %h we=%b, expected 00100080 0", device_addr_o[0],
               device_we_o[0]);
    end
    exp_q.push_back('{host: 0, rdata: 32'hDEADBEEF, err: 1'b0, due: cyc + 1});
    idle(3);
  endtask

  task automatic test_write();
    @(posedge clk); #1;
    drive(0, 32'h20000, 1'b1, 4'h1, 32'h41);
    #2;
    checks++;
    if (host_gnt_o[0] !== 1'b1 || dreq_vec() !== 3'b010) begin
      errors++;
      $display("FAIL write_req: got gnt0=%b dreq=%b, expected 1 010", host_gnt_o[0], dreq_vec());
    end
    checks++;
    if (device_we_o[1] !== 1'b1 || device_be_o[1] !== 4'h1 || device_wdata_o[1] !== 32'h41 ||
        device_addr_o[1] !== 32'h20000) begin
      errors++;
      $display("FAIL write_payload: got we=%b be=%h wdata=%h addr=%h, expected 1 1 00000041 00020000",
               device_we_o[1], device_be_o[1], device_wdata_o[1], device_addr_o[1]);
    end
    exp_q.push_back('{host: 0, rdata: 32'h11111111, err: 1'b0, due: cyc + 1});
    idle(3);
  endtask

  task automatic test_back_to_back();
    dev_err[2] = 1'b1;
    @(posedge clk); #1;
    drive(0, 32'h30004, 1'b0, 4'hF, 32'h0);
    #2;
    checks++;
    if (host_gnt_o[0] !== 1'b1 || dreq_vec() !== 3'b100 || device_addr_o[2] !== 32'h30004) begin
      errors++;
      $display("FAIL b2b_first: got gnt0=%b dreq=%b addr=%h, expected 1 100 00030004",
               host_gnt_o[0], dreq_vec(), device_addr_o[2]);
    end
    exp_q.push_back('{host: 0, rdata: 32'h22222222, err: 1'b1, due: cyc + 1});
    @(posedge clk); #1;
    drive(0, 32'h100000, 1'b0, 4'hF, 32'h0);
    #2;
    checks++;
    if (host_gnt_o[0] !== 1'b1 || dreq_vec() !== 3'b001 || device_addr_o[0] !== 32'h100000) begin
      errors++;
      $display("FAIL b2b_second: got gnt0=%b dreq=%b addr=%h, expected 1 001 00100000",
               host_gnt_o[0], dreq_vec(), device_addr_o[0]);
    end
    exp_q.push_back('{host: 0, rdata: 32'hDEADBEEF, err: 1'b0, due: cyc + 1});
    idle(3);
    dev_err[2] = 1'b0;
  endtask

  task automatic test_unmapped();
    @(posedge clk); #1;
    drive(0, 32'h50000, 1'b0, 4'hF, 32'h0);
    #2;
    checks++;
    if (dreq_vec() !== 3'b000) begin
      errors++;
      $display("FAIL unmapped_dreq: got %b, expected 000", dreq_vec());
    end
`ifdef BUS_DECODE_ERR_EN
    checks++;
    if (host_gnt_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL unmapped_gnt: got %b, expected 1", host_gnt_o[0]);
    end
    exp_q.push_back('{host: 0, rdata: 32'h0, err: 1'b1, due: cyc + 1});
`else
    repeat (3) begin
      checks++;
      if (host_gnt_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL unmapped_gnt: got %b, expected 0", host_gnt_o[0]);
      end
      @(posedge clk); #3;
    end
`endif
    idle(3);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    drive(0, 32'h100080, 1'b0, 4'hF, 32'h0);
    #2;
    checks++;
    if (host_gnt_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_gnt: got %b, expected 1", host_gnt_o[0]);
    end
    // Queued now; the monitor drops it once it sees reset.
    exp_q.push_back('{host: 0, rdata: 32'hDEADBEEF, err: 1'b0, due: cyc + 1});
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    checks++;
    if (host_rvalid_o[0] !== 1'b0 || host_gnt_o[0] !== 1'b0 || dreq_vec() !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_hold: got rvalid=%b gnt=%b dreq=%b, expected 0 0 000",
               host_rvalid_o[0], host_gnt_o[0], dreq_vec());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    host_req[0] = 1'b0;
    force_rvalid = 1'b1;
    #2;
    checks++;
    if (host_rvalid_o[0] !== 1'b0 || host_rvalid_o[1] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: got rvalid=%b%b, expected 00", host_rvalid_o[1],
               host_rvalid_o[0]);
    end
    @(posedge clk); #1;
    force_rvalid = 1'b0;
    drive(0, 32'h20000, 1'b0, 4'hF, 32'h0);
    #2;
    checks++;
    if (host_gnt_o[0] !== 1'b1 || dreq_vec() !== 3'b010) begin
      errors++;
      $display("FAIL rstmid_new: got gnt0=%b dreq=%b, expected 1 010", host_gnt_o[0], dreq_vec());
    end
    exp_q.push_back('{host: 0, rdata: 32'h11111111, err: 1'b0, due: cyc + 1});
    idle(3);
  endtask

  task automatic test_two_hosts();
    @(posedge clk); #1;
    drive(0, 32'h100000, 1'b0, 4'hF, 32'h0);
    drive(1, 32'h20004, 1'b0, 4'hF, 32'h0);
    #2;
    checks++;
    if (host_gnt_o[0] !== 1'b1 || host_gnt_o[1] !== 1'b0 || dreq_vec() !== 3'b001 ||
        device_addr_o[0] !== 32'h100000) begin
      errors++;
      $display("FAIL two_hosts_first: got gnt=%b%b dreq=%b addr=%h, expected 01 001 00100000",
               host_gnt_o[1], host_gnt_o[0], dreq_vec(), device_addr_o[0]);
    end
    exp_q.push_back('{host: 0, rdata: 32'hDEADBEEF, err: 1'b0, due: cyc + 1});
    @(posedge clk); #1;
    host_req[0] = 1'b0;
    #2;
    checks++;
    if (host_gnt_o[0] !== 1'b0 || host_gnt_o[1] !== 1'b1 || dreq_vec() !== 3'b010 ||
        device_addr_o[1] !== 32'h20004) begin
      errors++;
      $display("FAIL two_hosts_second: got gnt=%b%b dreq=%b addr=%h, expected 10 010 00020004",
               host_gnt_o[1], host_gnt_o[0], dreq_vec(), device_addr_o[1]);
    end
    exp_q.push_back('{host: 1, rdata: 32'h11111111, err: 1'b0, due: cyc + 1});
    idle(3);
  endtask

  initial begin
    rst = 1'b1;
    force_rvalid = 1'b0;
    cfg_base[0] = 32'h100000; cfg_mask[0] = ~32'hFFFFF;
    cfg_base[1] = 32'h20000;  cfg_mask[1] = ~32'h3FF;
    cfg_base[2] = 32'h30000;  cfg_mask[2] = ~32'h3FF;
    dev_data[0] = 32'hDEADBEEF; dev_data[1] = 32'h11111111; dev_data[2] = 32'h22222222;
    for (int d = 0; d < ND; d++) dev_err[d] = 1'b0;
    for (int h = 0; h < NH; h++) begin
      host_req[h] = 1'b0; host_addr[h] = '0; host_we[h] = 1'b0;
      host_be[h] = '0; host_wdata[h] = '0;
    end

    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_unmapped();
    test_reset_mid();
    test_two_hosts();

    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
